// File: rtl/divider_arb_pkg.sv
// Shared state type and sizing helpers for the divider arbiter and its picker.
package divider_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int TIMEOUT_PER_BIT  = 2;

    // An iterative divider needs about one cycle per bit; give it twice that.
    function automatic int timeout_for(input int width);
        return TIMEOUT_PER_BIT * width;
    endfunction

    // Index width that never collapses to zero bits for tiny requester counts.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/divider_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after last_grant,
// wrapping modulo NUM_REQ.
module rr_picker
    import divider_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one iterative divider between NUM_REQ clients.
// Build option DIV_ZERO_BYPASS_EN: zero divisors complete locally, divider never started.
//
// state | meaning
// IDLE  | nothing outstanding; grant when a request is up and the divider is free
// WAIT  | divider started; waiting for its done pulse or the watchdog
// DONE  | result captured; result pulse to the owner appears next cycle
module divider_arbiter
    import divider_arb_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = timeout_for(WIDTH)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0] dividend_in,
    input  logic [NUM_REQ*WIDTH-1:0] divisor_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic [NUM_REQ-1:0]       result_valid_out,
    output logic [WIDTH-1:0]         quotient_out,
    output logic [WIDTH-1:0]         remainder_out,
    output logic                     error_out,
    output logic                     busy_out,
    output logic [WIDTH-1:0]         div_dividend_out,
    output logic [WIDTH-1:0]         div_divisor_out,
    output logic                     div_valid_out,
    input  logic [WIDTH-1:0]         div_quotient_in,
    input  logic [WIDTH-1:0]         div_remainder_in,
    input  logic                     div_valid_in,
    input  logic                     div_error_in,
    input  logic                     div_busy_in
);

    localparam int               IDX_W    = idx_width(NUM_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   op_dividend_q, op_dividend_d;
    logic [WIDTH-1:0]   op_divisor_q, op_divisor_d;
    logic [WIDTH-1:0]   cap_quot_q, cap_quot_d;
    logic [WIDTH-1:0]   cap_rem_q, cap_rem_d;
    logic               cap_err_q, cap_err_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               start_q, start_d;
    logic [NUM_REQ-1:0] result_valid_q, result_valid_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               error_q, error_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               arb_go;
    logic               timeout;
    logic               bypass_zero;
    logic [WIDTH-1:0]   sel_dividend;
    logic [WIDTH-1:0]   sel_divisor;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_valid_in),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_dividend = dividend_in[i*WIDTH +: WIDTH];
                sel_divisor  = divisor_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign arb_go  = (state_q == IDLE) && grant_any && !div_busy_in;
    assign timeout = (cnt_q == CNT_LAST);

`ifdef DIV_ZERO_BYPASS_EN
    assign bypass_zero = (sel_divisor == '0);
`else
    assign bypass_zero = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            last_grant_q   <= IDX_W'(NUM_REQ - 1);
            owner_q        <= '0;
            cnt_q          <= '0;
            op_dividend_q  <= '0;
            op_divisor_q   <= '0;
            cap_quot_q     <= '0;
            cap_rem_q      <= '0;
            cap_err_q      <= 1'b0;
            ready_q        <= '0;
            start_q        <= 1'b0;
            result_valid_q <= '0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            op_dividend_q  <= op_dividend_d;
            op_divisor_q   <= op_divisor_d;
            cap_quot_q     <= cap_quot_d;
            cap_rem_q      <= cap_rem_d;
            cap_err_q      <= cap_err_d;
            ready_q        <= ready_d;
            start_q        <= start_d;
            result_valid_q <= result_valid_d;
            quotient_q     <= quotient_d;
            remainder_q    <= remainder_d;
            error_q        <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_go) state_d = bypass_zero ? DONE : WAIT;
            WAIT:    if (div_valid_in || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        op_dividend_d  = op_dividend_q;
        op_divisor_d   = op_divisor_q;
        cap_quot_d     = cap_quot_q;
        cap_rem_d      = cap_rem_q;
        cap_err_d      = cap_err_q;
        ready_d        = '0;
        start_d        = 1'b0;
        result_valid_d = '0;
        quotient_d     = quotient_q;
        remainder_d    = remainder_q;
        error_d        = error_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (arb_go) begin
                    last_grant_d  = grant_idx;
                    owner_d       = grant;
                    op_dividend_d = sel_dividend;
                    op_divisor_d  = sel_divisor;
                    ready_d       = grant;
                    start_d       = !bypass_zero;
                    if (bypass_zero) begin
                        cap_quot_d = '1;
                        cap_rem_d  = sel_dividend;
                        cap_err_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A reply on the watchdog's last cycle still carries real data.
                if (div_valid_in) begin
                    cap_quot_d = div_quotient_in;
                    cap_rem_d  = div_remainder_in;
                    cap_err_d  = div_error_in;
                end else if (timeout) begin
                    cap_quot_d = '0;
                    cap_rem_d  = '0;
                    cap_err_d  = 1'b1;
                end
            end
            DONE: begin
                result_valid_d = owner_q;
                quotient_d     = cap_quot_q;
                remainder_d    = cap_rem_q;
                error_d        = cap_err_q;
            end
            default: ;
        endcase
    end

    assign req_ready_out    = ready_q;
    assign div_valid_out    = start_q;
    assign div_dividend_out = op_dividend_q;
    assign div_divisor_out  = op_divisor_q;
    assign result_valid_out = result_valid_q;
    assign quotient_out     = quotient_q;
    assign remainder_out    = remainder_q;
    assign error_out        = error_q;
    assign busy_out         = (state_q != IDLE);

endmodule
